// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader and the CPU core
// (instruction width, frame constants, loader state encoding).
package prog_loader_pkg;

    localparam int          INSTR_W       = 19;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0]  B2_RSVD_MASK  = 8'hF8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-lane assembler: latches B0/B1 and forms the 19-bit word from the
// B2 byte currently on the bus, flagging any set reserved bits in B2.
module prog_loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_i,
    input  logic               cap_b0_i,
    input  logic               cap_b1_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               rsvd_err_o
);

    logic [7:0] b0_q;
    logic [7:0] b1_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            if (cap_b0_i) b0_q <= data_i;
            if (cap_b1_i) b1_q <= data_i;
        end
    end

    assign word_o     = {data_i[2:0], b1_q, b0_q};
    assign rsvd_err_o = |(data_i & B2_RSVD_MASK);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC/LEN/words[/CHK] frames into instruction
// memory and releases the CPU once the image is accepted. Optional checksum byte
// enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_run,
    output logic               done,
    output logic               error
);

    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FIN_STATE = S_CHECK;
`else
    localparam state_t FIN_STATE = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [INSTR_W-1:0]  imem_wdata_q;
    logic                cpu_run_q, done_q, error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic                acc;
    logic                wr_word;
    logic [INSTR_W-1:0]  word;
    logic                rsvd_err;
    logic [15:0]         len_full;

    assign acc      = rx_valid && rx_ready;
    assign len_full = {rx_byte, len_q[7:0]};
    assign wr_word  = acc && (state_q == S_B2) && !rsvd_err;

    prog_loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .data_i     (rx_byte),
        .cap_b0_i   (acc && (state_q == S_B0)),
        .cap_b1_i   (acc && (state_q == S_B1)),
        .word_o     (word),
        .rsvd_err_o (rsvd_err)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        rx_ready = 1'b0;
        case (state_q)
            S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CHECK: rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (acc && rx_byte == SYNC_BYTE) begin
                    state_d = S_LEN_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d[7:0] = rx_byte;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_d[15:8] = rx_byte;
                    idx_d       = '0;
                    if ({1'b0, len_full} > MAX_LEN) state_d = S_ERR;
                    else if (len_full == 16'd0)     state_d = FIN_STATE;
                    else                            state_d = S_B0;
                end
            end
            S_B0:    if (acc) state_d = S_B1;
            S_B1:    if (acc) state_d = S_B2;
            S_B2:    if (acc) state_d = rsvd_err ? S_ERR : S_WRITE;
            S_WRITE: begin
                idx_d = idx_q + 1'b1;
                // Index is one bit wider than the address so a full-size image ends cleanly.
                if (17'(idx_q) + 17'd1 == {1'b0, len_q}) state_d = FIN_STATE;
                else                                      state_d = S_B0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: if (acc) state_d = (rx_byte == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = state_q;
        endcase

`ifdef PROG_LOADER_CHECKSUM_EN
        if (acc && state_q inside {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2})
            chk_d = chk_d ^ rx_byte;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            imem_we_q <= wr_word;
            if (wr_word) begin
                imem_addr_q  <= idx_q[ADDR_W-1:0];
                imem_wdata_q <= word;
            end
            cpu_run_q <= (state_d == S_DONE);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERR);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) chk_q <= '0;
        else      chk_q <= chk_d;
    end
`endif

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
